inv_sub_bytes_seq: RTL and testbench

//  Sequential AES-128 InvSubBytes stage for the decryption datapath.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/inv_sbox.sv | 22 ++
 rtl/inv_sub_bytes_seq.sv | 141 ++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, types and S-box tables.
//   AES_STATE_W / AES_NBYTES : state width and byte count
//   aes_byte_t               : one state byte
//   fsm_state_t              : InvSubBytes sequencer states
//   SBOX / INV_SBOX          : forward and inverse substitution tables,
//                              indexed directly by the byte value
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_NBYTES  = 16;

   typedef logic [7:0] aes_byte_t;

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      DONE
   } fsm_state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: combinational byte substitution, one instance per lane.
//   fwd      in  1  select forward S-box (only with INV_SUB_FWD_EN defined)
//   in_byte  in  8  byte to substitute
//   out_byte out 8  substituted byte
// Macro INV_SUB_FWD_EN: when undefined only the inverse table exists.
module inv_sbox
   import aes_pkg::*;
(
`ifdef INV_SUB_FWD_EN
   input  logic       fwd,
`endif
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

`ifdef INV_SUB_FWD_EN
   assign out_byte = fwd ? SBOX[in_byte] : INV_SBOX[in_byte];
`else
   assign out_byte = INV_SBOX[in_byte];
`endif

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes, LANES bytes per cycle.
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    input state valid
//   in_ready   out  1    accepting a state (IDLE only)
//   in_data    in   128  state, byte 0 = [127:120]
//   mode_fwd   in   1    forward S-box select, sampled at accept
//                        (only with INV_SUB_FWD_EN defined)
//   out_valid  out  1    result valid (DONE)
//   out_ready  in   1    downstream accepts result
//   out_data   out  128  substituted state, zero unless out_valid
//   busy       out  1    substitution in progress
// Macro INV_SUB_FWD_EN adds mode_fwd and the forward S-box tables.
//
// state | meaning
// IDLE  | waiting for a state, in_ready=1
// SUB   | substituting one LANES-byte group per cycle
// DONE  | result held on out_data until out_ready
module inv_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int LANES = 4
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
`ifdef INV_SUB_FWD_EN
   input  logic         mode_fwd,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int NGRP   = AES_NBYTES / LANES;
   localparam int CNT_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int LANE_W = 8 * LANES;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

   if ((LANES < 1) || (AES_NBYTES % LANES != 0)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must divide 16");
   end

   fsm_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [AES_STATE_W-1:0] data_q, data_d, data_sub;
   logic [LANE_W-1:0]      lane_out;
`ifdef INV_SUB_FWD_EN
   logic                   fwd_q, fwd_d;
`endif

   // The group being substituted is always the top LANES bytes; the state
   // rotates left by one group per cycle, so after NGRP cycles every byte
   // has been replaced once, byte 0 first, and the original order is back.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      inv_sbox u_sbox (
`ifdef INV_SUB_FWD_EN
         .fwd      (fwd_q),
`endif
         .in_byte  (data_q[AES_STATE_W-1-8*l -: 8]),
         .out_byte (lane_out[LANE_W-1-8*l -: 8])
      );
   end

   if (LANES == AES_NBYTES) begin : g_full
      assign data_sub = lane_out;
   end else begin : g_rot
      assign data_sub = {data_q[AES_STATE_W-LANE_W-1:0], lane_out};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
`ifdef INV_SUB_FWD_EN
         fwd_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
`ifdef INV_SUB_FWD_EN
         fwd_q   <= fwd_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
`ifdef INV_SUB_FWD_EN
      fwd_d     = fwd_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d  = in_data;
               cnt_d   = '0;
`ifdef INV_SUB_FWD_EN
               fwd_d   = mode_fwd;
`endif
               state_d = SUB;
            end
         end
         SUB: begin
            busy   = 1'b1;
            data_d = data_sub;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Intermediate SUB contents never reach the port.
   assign out_data = (state_q == DONE) ? data_q : '0;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: self-checking bench for inv_sub_bytes_seq.
// Three instances (LANES = 4, 1, 16). Expected data comes from spec
// constants or from S-boxes computed here from GF(2^8) arithmetic.
// Latency is counted in clock edges with the accept edge as edge 1.
// Macro INV_SUB_FWD_EN enables the forward-mode checks.
module tb_inv_sub_bytes_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_data   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_data  [3];
   logic         busy      [3];
`ifdef INV_SUB_FWD_EN
   logic         mode_fwd  [3];
`endif

   int lanes_of [3] = '{4, 1, 16};

   int checks = 0;
   int errors = 0;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   inv_sub_bytes_seq #(.LANES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
`ifdef INV_SUB_FWD_EN
      .mode_fwd(mode_fwd[0]),
`endif
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .busy(busy[0])
   );

   inv_sub_bytes_seq #(.LANES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
`ifdef INV_SUB_FWD_EN
      .mode_fwd(mode_fwd[1]),
`endif
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .busy(busy[1])
   );

   inv_sub_bytes_seq #(.LANES(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
`ifdef INV_SUB_FWD_EN
      .mode_fwd(mode_fwd[2]),
`endif
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .busy(busy[2])
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(logic [7:0] b, int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_calc(logic [7:0] x);
      logic [7:0] v = 8'h00;
      if (x != 8'h00) begin
         for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
      end
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_sub(logic [127:0] din, bit fwd);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[127-8*i -: 8] = fwd ? fwd_tab[din[127-8*i -: 8]] : inv_tab[din[127-8*i -: 8]];
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One transaction with out_ready held high; returns data and latency.
   task automatic xact(input int d, input logic [127:0] din,
                       output logic [127:0] got, output int lat);
      bit ok;
      @(negedge clk);
      chk("in_ready_before_accept", 128'(in_ready[d]), 128'd1);
      in_valid[d]  = 1'b1;
      in_data[d]   = din;
      out_ready[d] = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid[d] = 1'b0;
      in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
      ok = 1'b1;
      while (!out_valid[d] && lat < 40) begin
         if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1 || out_data[d] !== '0) ok = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("sub_phase_flags", 128'(ok), 128'd1);
      chk("out_valid_timeout", 128'(out_valid[d]), 128'd1);
      chk("in_ready_in_done", 128'(in_ready[d]), 128'd0);
      got = out_data[d];
      @(posedge clk);
      @(negedge clk);
      chk("out_valid_after_hs", 128'(out_valid[d]), 128'd0);
      chk("in_ready_after_hs", 128'(in_ready[d]), 128'd1);
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic [127:0] got;
      logic [127:0] din;
      logic [127:0] exp;
      int           lat;
      int           n;
      bit           ok;

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b0;
`ifdef INV_SUB_FWD_EN
         mode_fwd[d]  = 1'b0;
`endif
      end

      for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_calc(8'(i));
      for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

      vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
      vecs[1] = '{128'h00000000000000000000000000000000, {16{8'h52}}};
      vecs[2] = '{128'hffffffffffffffffffffffffffffffff, {16{8'h7d}}};
      vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};

      // Reset values, checked both during and after reset.
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
         chk("rst_busy", 128'(busy[d]), 128'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("idle_in_ready", 128'(in_ready[d]), 128'd1);
         chk("idle_out_valid", 128'(out_valid[d]), 128'd0);
         chk("idle_out_data", out_data[d], 128'd0);
         chk("idle_busy", 128'(busy[d]), 128'd0);
      end

      // Spec vectors, back-to-back, on every lane width.
      for (int d = 0; d < 3; d++) begin
         for (int v = 0; v < 4; v++) begin
            xact(d, vecs[v].din, got, lat);
            chk("vec_data", got, vecs[v].exp);
            chk("vec_latency", 128'(lat), 128'(16 / lanes_of[d] + 1));
         end
      end

      // Random states against the computed model.
      for (int i = 0; i < 24; i++) begin
         int d = i % 3;
         din = {$urandom, $urandom, $urandom, $urandom};
         xact(d, din, got, lat);
         chk("rand_data", got, ref_sub(din, 1'b0));
         chk("rand_latency", 128'(lat), 128'(16 / lanes_of[d] + 1));
      end

      // Backpressure in DONE with a competing in_valid.
      @(negedge clk);
      in_valid[0]  = 1'b1;
      in_data[0]   = vecs[0].din;
      out_ready[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 40) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("bp_reach_done", 128'(out_valid[0]), 128'd1);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         @(negedge clk);
         if (out_valid[0] !== 1'b1 || out_data[0] !== vecs[0].exp ||
             in_ready[0] !== 1'b0 || busy[0] !== 1'b0) ok = 1'b0;
      end
      chk("bp_hold", 128'(ok), 128'd1);
      chk("bp_data", out_data[0], vecs[0].exp);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_valid", 128'(out_valid[0]), 128'd0);
      chk("bp_release_ready", 128'(in_ready[0]), 128'd1);
      chk("bp_no_new_accept", 128'(busy[0]), 128'd0);

      // Reset on the second SUB cycle.
      in_valid[0] = 1'b1;
      in_data[0]  = vecs[0].din;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", 128'(busy[0]), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("midsub_rst_busy", 128'(busy[0]), 128'd0);
      chk("midsub_rst_in_ready", 128'(in_ready[0]), 128'd1);
      chk("midsub_rst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("midsub_rst_out_data", out_data[0], 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      xact(0, vecs[0].din, got, lat);
      chk("post_rst_data", got, vecs[0].exp);
      chk("post_rst_latency", 128'(lat), 128'd5);

      // Reset while held in DONE.
      @(negedge clk);
      in_valid[0]  = 1'b1;
      in_data[0]   = vecs[2].din;
      out_ready[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("done_before_rst", out_data[0], vecs[2].exp);
      rst_n = 1'b0;
      #1;
      chk("done_rst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("done_rst_out_data", out_data[0], 128'd0);
      chk("done_rst_in_ready", 128'(in_ready[0]), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      xact(0, vecs[1].din, got, lat);
      chk("post_done_rst_data", got, vecs[1].exp);

`ifdef INV_SUB_FWD_EN
      for (int d = 0; d < 3; d++) begin
         mode_fwd[d] = 1'b1;
         xact(d, 128'h000102030405060708090a0b0c0d0e0f, got, lat);
         mode_fwd[d] = 1'b0;
         chk("fwd_vec", got, 128'h637c777bf26b6fc53001672bfed7ab76);
         din = {$urandom, $urandom, $urandom, $urandom};
         exp = ref_sub(din, 1'b1);
         mode_fwd[d] = 1'b1;
         xact(d, din, got, lat);
         mode_fwd[d] = 1'b0;
         chk("fwd_rand", got, exp);
         xact(d, vecs[0].din, got, lat);
         chk("inv_after_fwd", got, vecs[0].exp);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
